// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug-side reader that dumps the ID-stage register file to the host while
//   the pipeline is halted. A start pulse walks addresses 0..NUM_REGS-1 through
//   a dedicated combinational read port and serializes each DATA_W-bit value
//   MSB-first as bytes onto a valid/ready stream feeding the debug UART.
//
// Ports
//   clk       in   1       system clock
//   reset     in   1       synchronous, active-high reset (priority over abort)
//   start     in   1       one-cycle dump request, ignored while busy
//   abort     in   1       synchronous abort back to IDLE, no done pulse
//   rd_addr   out  ADDR_W  register-file read address
//   rd_data   in   DATA_W  combinational read data for rd_addr
//   tx_data   out  8       byte presented to the transmitter
//   tx_valid  out  1       tx_data is valid
//   tx_ready  in   1       transmitter accepts the byte this cycle
//   busy      out  1       high in any state other than IDLE
//   done      out  1       one-cycle pulse after the last byte is accepted
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, busy_q, done_q;
  logic              xfer;

  // A byte leaves only while SEND is presenting it and the UART takes it.
  assign xfer = (state_q == S_SEND) && tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Single capture point per register: later register-file writes to
        // this address are not reflected in the dump.
        shreg_d = rd_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          shreg_d = shreg_q << 8;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_READ;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides everything, including a start arriving in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from the next-state so they change only on edges
  // and stay frozen while SEND is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == S_SEND);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign rd_addr  = addr_q;
  assign tx_data  = shreg_q[DATA_W-1 -: 8];
  assign tx_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
